// File: rtl/bridge_pkg.sv
// Shared definitions for the I2C-to-UART bridge: UART transmitter FSM encoding and defaults.
package bridge_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter; bit_tick marks the last clk of each bit.
module uart_baud_gen
    import bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int              CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = !clear && (cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
module fifo_uart_tx
    import bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_underflow,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       underflow_err
);

    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] data_reg;
    logic [2:0] bit_idx;
    logic       bit_tick;
    logic       baud_clear;
    logic       last_bit;

    assign baud_clear = (state == ST_IDLE) || (state == ST_LOAD);
    assign last_bit   = (bit_idx == 3'(UART_DATA_BITS - 1));
    assign busy       = (state != ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        tx         = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_en && !fifo_empty && !reset) begin
                    fifo_rd_en = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = fifo_underflow ? ST_IDLE : ST_START;
            end
            ST_START: begin
                tx = 1'b0;
                if (bit_tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                tx = data_reg[bit_idx];
                if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx = ^data_reg;
                if (bit_tick) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    frame_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            data_reg      <= '0;
            bit_idx       <= '0;
            underflow_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_LOAD) begin
                data_reg <= fifo_rd_data;
                if (fifo_underflow) underflow_err <= 1'b1;
            end
            // 3-bit index wraps 7 -> 0 on its own, ready for the next frame.
            if (state == ST_DATA && bit_tick) bit_idx <= bit_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4 and a queue-based FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB  = 11;
`else
    localparam int FB  = 10;
`endif

    logic       clk;
    logic       reset;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_underflow;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       underflow_err;

    logic [7:0] q[$];
    logic       force_uf;
    int         rd_total;
    int         checks;
    int         failures;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_en         (tx_en),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_underflow(fifo_underflow),
        .fifo_rd_en    (fifo_rd_en),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .underflow_err (underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty = (q.size() == 0);

    // FIFO read side: data valid the cycle after the strobe.
    always @(posedge clk) begin
        fifo_underflow <= fifo_rd_en && force_uf;
        if (fifo_rd_en) begin
            rd_total <= rd_total + 1;
            if (q.size() > 0) fifo_rd_data <= q.pop_front();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns cycles until fifo_rd_en is seen (0 = now), or -1 if not within limit.
    task automatic wait_rd(input int limit, output int n);
        n = -1;
        for (int i = 0; i <= limit; i++) begin
            if (fifo_rd_en === 1'b1) begin
                n = i;
                break;
            end
            if (i < limit) @(negedge clk);
        end
    endtask

    // Entered in the read-strobe cycle; returns in the last stop-bit cycle.
    task automatic expect_frame(input logic [7:0] exp);
        logic eb;
        logic obs;
        int   fd_pos;
        int   fd_cnt;
        int   busy_low;
        int   rd_seen;
        int   k;
        fd_pos = -1; fd_cnt = 0; busy_low = 0; rd_seen = 0; k = 0;
        @(negedge clk);
        check("load_tx_high", tx, 1);
        check("load_busy", busy, 1);
        for (int b = 0; b < FB; b++) begin
            if (b == 0)           eb = 1'b0;
            else if (b <= 8)      eb = exp[b-1];
            else if (b == FB - 1) eb = 1'b1;
            else                  eb = ^exp;
            obs = eb;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx !== eb) obs = tx;
                if (frame_done === 1'b1) begin
                    fd_cnt++;
                    if (fd_pos < 0) fd_pos = k;
                end
                if (busy !== 1'b1) busy_low++;
                if (fifo_rd_en !== 1'b0) rd_seen++;
                k++;
            end
            check($sformatf("bit%0d_of_%02h", b, exp), obs, eb);
        end
        check("frame_done_pos", fd_pos, FB * CPB - 1);
        check("frame_done_count", fd_cnt, 1);
        check("frame_busy", busy_low, 0);
        check("frame_no_read", rd_seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rd_base;
        logic tx_min;
        checks = 0; failures = 0; rd_total = 0;
        reset = 1'b1; tx_en = 1'b0; force_uf = 1'b0;
        fifo_underflow = 1'b0; fifo_rd_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_uf_err", underflow_err, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single frame 8'hA5
        q.push_back(8'hA5);
        tx_en = 1'b1;
        #1;
        wait_rd(20, n);
        check("a5_rd_latency", n, 0);
        expect_frame(8'hA5);
        wait_rd(10, n);
        check("a5_no_extra_rd", n, -1);
        check("a5_idle_busy", busy, 0);

        // Back-to-back frames
        rd_base = rd_total;
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
        #1;
        wait_rd(20, n);
        check("b2b_first_rd", n, 0);
        expect_frame(8'h00);
        wait_rd(10, n);
        check("b2b_gap_1", n, 1);
        expect_frame(8'hFF);
        wait_rd(10, n);
        check("b2b_gap_2", n, 1);
        expect_frame(8'h55);
        wait_rd(10, n);
        check("b2b_no_more", n, -1);
        check("b2b_read_count", rd_total - rd_base, 3);

        // tx_en gating
        tx_en = 1'b0;
        q.push_back(8'h3C); q.push_back(8'hC3);
        #1;
        wait_rd(20, n);
        check("txen_off_no_rd", n, -1);
        check("txen_off_tx", tx, 1);
        tx_en = 1'b1;
        #1;
        wait_rd(5, n);
        check("txen_on_rd", n, 0);
        fork
            expect_frame(8'h3C);
            begin
                repeat (15) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        wait_rd(20, n);
        check("txen_drop_no_rd", n, -1);
        check("txen_fifo_left", q.size(), 1);
        tx_en = 1'b1;
        #1;
        wait_rd(5, n);
        check("txen_resume_rd", n, 0);
        expect_frame(8'hC3);

        // Reset during data bit 3
        @(negedge clk);
        q.push_back(8'h96);
        #1;
        wait_rd(20, n);
        check("rstmid_rd", n, 0);
        repeat (19) @(negedge clk);
        check("rstmid_busy_before", busy, 1);
        reset = 1'b1;
        check("rstmid_no_rd_in_reset", fifo_rd_en, 0);
        @(negedge clk);
        check("rstmid_tx", tx, 1);
        check("rstmid_busy", busy, 0);
        reset = 1'b0;
        #1;
        wait_rd(20, n);
        check("rstmid_stay_idle", n, -1);
        check("rstmid_idle_tx", tx, 1);

        // Underflow reported in LOAD
        force_uf = 1'b1;
        q.push_back(8'h11);
        #1;
        wait_rd(20, n);
        check("uf_rd", n, 0);
        @(negedge clk);
        check("uf_load_busy", busy, 1);
        force_uf = 1'b0;
        @(negedge clk);
        check("uf_err_set", underflow_err, 1);
        check("uf_back_idle", busy, 0);
        tx_min = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (tx !== 1'b1) tx_min = tx;
            @(negedge clk);
        end
        check("uf_no_start_bit", tx_min, 1);
        check("uf_err_sticky", underflow_err, 1);

        // Odd-parity payload (parity bit 1 when compiled in)
        q.push_back(8'h07);
        #1;
        wait_rd(20, n);
        check("p07_rd", n, 0);
        expect_frame(8'h07);
        check("p07_err_still_set", underflow_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
